instruction_encoder: RTL and testbench

Packs decoded instruction fields (format, registers, funct bits, 64-bit immediate) into 32-bit RV64 machine words for the R, I-load, S-store and SB-branch formats. It is the inverse of the core's immediate extraction: for every supported format, feeding `out_instr` back through the extractor returns the original sign-extended `imm`. The block sits in the program-loader path ahead of instruction memory. It tags each word with its word-aligned byte address and buffers results in a small FIFO behind valid/ready handshakes.

---
 rtl/instruction_encoder.sv | 131 +++++++++++++
 tb/tb_instruction_encoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// RV64 R/I/S/SB instruction packer with word-address tagging and an output FIFO.
// Optional immediate range check/drop enabled by defining IMM_RANGE_CHECK_EN.
module instruction_encoder #(
    parameter int                DEPTH     = 2,
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         fmt,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic signed [63:0] imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               err_imm
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    function automatic logic [31:0] encode(
        input logic [1:0]         f,
        input logic [4:0]         d,
        input logic [4:0]         s1,
        input logic [4:0]         s2,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic signed [63:0] im
    );
        logic [31:0] w;
        w = '0;
        case (f)
            2'b00: w = {f7, s2, s1, f3, d, 7'b0110011};
            2'b01: w = {im[11:0], s1, f3, d, 7'b0000011};
            2'b10: w = {im[11:5], s2, s1, f3, im[4:0], 7'b0100011};
            default: w = {im[11], im[9:4], s2, s1, f3, im[3:0], im[10], 7'b1100011};
        endcase
        return w;
    endfunction

    logic [31:0]       instr_p0;
    logic              vld_p0;
    logic              keep_p0;
    logic              push;
    logic              pop;
    logic [31:0]       mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_cnt;
    logic              err_q;

    // encode stage: combinational pack of the offered bundle
    assign instr_p0 = encode(fmt, rd, rs1, rs2, funct3, funct7, imm);
    assign in_ready = (count != FULL) && !clear;
    assign vld_p0   = in_valid && in_ready;

`ifdef IMM_RANGE_CHECK_EN
    function automatic logic imm_fits12(input logic signed [63:0] im);
        return (&im[63:11]) || !(|im[63:11]);
    endfunction

    logic bad_p0;
    assign bad_p0  = (fmt != 2'b00) && !imm_fits12(imm);
    assign keep_p0 = !bad_p0;

    always_ff @(posedge clk) begin
        if (reset || clear)
            err_q <= 1'b0;
        else if (vld_p0 && bad_p0)
            err_q <= 1'b1;
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[63:12];
    assign keep_p0 = 1'b1;

    always_ff @(posedge clk) begin
        err_q <= 1'b0;
    end
`endif

    assign push = vld_p0 && keep_p0;
    assign pop  = out_valid && out_ready;

    // FIFO stage: storage is not reset; emptiness is tracked by count alone
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= instr_p0;
            mem_addr[wr_ptr]  <= addr_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            addr_cnt <= BASE_ADDR;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                addr_cnt <= addr_cnt + ADDR_W'(4);
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr]  : '0;
    assign err_imm   = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed, table-driven bench for instruction_encoder (DEPTH=2, BASE_ADDR=0).
module tb_instruction_encoder;

    logic               clk = 1'b0;
    logic               reset, clear, in_valid, in_ready;
    logic [1:0]         fmt;
    logic [4:0]         rd, rs1, rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [63:0] imm;
    logic               out_valid, out_ready, err_imm;
    logic [31:0]        out_instr;
    logic [63:0]        out_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.DEPTH(2), .ADDR_W(64), .BASE_ADDR(64'h0)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err_imm(err_imm)
    );

    typedef struct {
        logic [1:0]         f;
        logic [4:0]         d, s1, s2;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic signed [63:0] im;
        logic [31:0]        exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fmt = v.f; rd = v.d; rs1 = v.s1; rs2 = v.s2;
        funct3 = v.f3; funct7 = v.f7; imm = v.im;
        in_valid = 1'b1;
    endtask

    task automatic push_one(input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // independent immediate decoder, as the core's extractor would see the word
    function automatic logic [63:0] extract(input logic [1:0] f, input logic [31:0] w);
        logic [11:0] x;
        case (f)
            2'b01:   x = w[31:20];
            2'b10:   x = {w[31:25], w[11:7]};
            default: x = {w[31], w[7], w[30:25], w[11:8]};
        endcase
        return {{52{x[11]}}, x};
    endfunction

    vec_t big;

    initial begin
        vecs[0]  = '{2'b01, 5'd5,  5'd2,  5'd31, 3'd3, 7'h7f, 64'sd8,     32'h00813283};
        vecs[1]  = '{2'b10, 5'd9,  5'd2,  5'd5,  3'd3, 7'h00, -64'sd8,    32'hFE513C23};
        vecs[2]  = '{2'b00, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 64'sd0,     32'h002081B3};
        vecs[3]  = '{2'b11, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 64'sd4,     32'h00208463};
        vecs[4]  = '{2'b00, 5'd1,  5'd2,  5'd3,  3'd0, 7'h20, 64'sh0000_1000_0000_0000, 32'h403100B3};
        vecs[5]  = '{2'b01, 5'd10, 5'd11, 5'd0,  3'd3, 7'h00, -64'sd1,    32'hFFF5B503};
        vecs[6]  = '{2'b01, 5'd1,  5'd0,  5'd0,  3'd2, 7'h00, -64'sd2048, 32'h80002083};
        vecs[7]  = '{2'b01, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 64'sd2047,  32'h7FF00003};
        vecs[8]  = '{2'b10, 5'd0,  5'd31, 5'd31, 3'd7, 7'h00, 64'sd2047,  32'h7FFFFFA3};
        vecs[9]  = '{2'b11, 5'd0,  5'd0,  5'd0,  3'd1, 7'h00, -64'sd1,    32'hFE001FE3};
        vecs[10] = '{2'b11, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 64'sd1024,  32'h000000E3};
        big      = '{2'b01, 5'd5,  5'd2,  5'd0,  3'd3, 7'h00, 64'sd2048,  32'h80013283};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst_out_addr",  out_addr,           64'd0);
        check("rst_err_imm",   {63'd0, err_imm},   64'd0);

        // streaming table: one word per cycle, simultaneous push and pop
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d_instr", i), {32'd0, out_instr}, {32'd0, vecs[i].exp});
            check($sformatf("vec%0d_addr", i),  out_addr, 64'(i * 4));
            if (vecs[i].f != 2'b00)
                check($sformatf("vec%0d_roundtrip", i), extract(vecs[i].f, out_instr), vecs[i].im);
        end
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
        #1 check("stream_drained", {63'd0, out_valid}, 64'd0);

        // back-pressure with a full FIFO
        @(negedge clk) clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        out_ready = 1'b0;
        @(negedge clk) drive(vecs[0]);
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_2nd", {63'd0, in_ready}, 64'd1);
        drive(vecs[2]);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[3]);
        check("bp_full_ready", {63'd0, in_ready}, 64'd0);
        check("bp_head_instr", {32'd0, out_instr}, 64'h00813283);
        check("bp_head_addr",  out_addr, 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_instr", {32'd0, out_instr}, 64'h00813283);
        out_ready = 1'b1;
        #1 check("bp_full_pop_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_pop1_instr", {32'd0, out_instr}, 64'h002081B3);
        check("bp_pop1_addr",  out_addr, 64'h4);
        check("bp_slot_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_b_still_head", out_addr, 64'h4);
        @(posedge clk);
        #1;
        check("bp_c_instr", {32'd0, out_instr}, 64'h00208463);
        check("bp_c_addr",  out_addr, 64'h8);
        @(posedge clk);
        #1 check("bp_drained", {63'd0, out_valid}, 64'd0);

        // immediate just outside the 12-bit signed range
        @(negedge clk) clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("rng_err_before", {63'd0, err_imm}, 64'd0);
        push_one(big);
`ifdef IMM_RANGE_CHECK_EN
        check("rng_dropped", {63'd0, out_valid}, 64'd0);
        check("rng_err_set", {63'd0, err_imm},   64'd1);
        push_one(vecs[0]);
        check("rng_next_instr", {32'd0, out_instr}, 64'h00813283);
        check("rng_next_addr",  out_addr, 64'h0);
        check("rng_err_sticky", {63'd0, err_imm}, 64'd1);
`else
        check("rng_valid", {63'd0, out_valid}, 64'd1);
        check("rng_instr", {32'd0, out_instr}, {32'd0, big.exp});
        check("rng_addr",  out_addr, 64'h0);
        check("rng_err",   {63'd0, err_imm}, 64'd0);
`endif
        @(posedge clk);
        #1 check("rng_drained", {63'd0, out_valid}, 64'd0);

        // clear mid-stream with a simultaneous push
        out_ready = 1'b0;
        push_one(vecs[0]);
        push_one(vecs[2]);
        @(negedge clk);
        check("clr_pre_valid", {63'd0, out_valid}, 64'd1);
        clear = 1'b1;
        drive(vecs[3]);
        #1 check("clr_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", {63'd0, out_valid}, 64'd0);
        check("clr_err_imm",   {63'd0, err_imm},   64'd0);
        out_ready = 1'b1;
        push_one(vecs[1]);
        check("clr_next_instr", {32'd0, out_instr}, 64'hFE513C23);
        check("clr_next_addr",  out_addr, 64'h0);
        @(posedge clk);

        // reset mid-stream with a simultaneous push
        out_ready = 1'b0;
        push_one(vecs[0]);
        push_one(vecs[2]);
        @(negedge clk);
        reset = 1'b1;
        drive(vecs[3]);
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst2_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst2_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst2_err_imm",   {63'd0, err_imm},   64'd0);
        out_ready = 1'b1;
        push_one(vecs[3]);
        check("rst2_next_instr", {32'd0, out_instr}, 64'h00208463);
        check("rst2_next_addr",  out_addr, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
